filter_sched: RTL and testbench

FILTER_SCHED -- requirements
Module: filter_sched

---
 rtl/filter_sched.sv | 99 +++++++++
 tb/tb_filter_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sched.sv
// Four-channel encoder-line debounce filter that time-shares one stability evaluator.
// Define FILTER_SCHED_CHG_EN to add the chg/chg_ch change-event outputs.
module filter_sched #(
    parameter int size = 3,
    parameter int div  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q,
    output logic [3:0] qf
`ifdef FILTER_SCHED_CHG_EN
    ,
    output logic       chg,
    output logic [1:0] chg_ch
`endif
);

    localparam logic [7:0] reload = 8'(div);

    logic [7:0]      cnt;
    logic [1:0]      idx;
    logic [size-1:0] hist [4];

    logic            service;
    logic [size-1:0] cur_hist;
    logic            cur_qf;
    logic            new_qf;
    logic            sample;

    // The decision uses the history as it stood before this slot's sample shifts in.
    always_comb begin
        service  = (cnt == 8'd0);
        cur_hist = hist[idx];
        cur_qf   = qf[idx];
        sample   = q[idx];
        new_qf   = cur_qf;
        if (&cur_hist) begin
            new_qf = 1'b1;
        end else if (~|cur_hist) begin
            new_qf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (service) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
        end else if (service) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                hist[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (service && (idx == 2'(ch))) begin
                    hist[ch] <= {hist[ch][size-2:0], sample};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qf <= 4'd0;
        end else if (service) begin
            qf[idx] <= new_qf;
        end
    end

`ifdef FILTER_SCHED_CHG_EN
    // chg_ch keeps the last reported channel between events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg    <= 1'b0;
            chg_ch <= 2'd0;
        end else begin
            chg <= service && (new_qf != cur_qf);
            if (service && (new_qf != cur_qf)) begin
                chg_ch <= idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_filter_sched.sv
// Scoreboard bench for filter_sched: three configurations share one stimulus stream,
// each checked every cycle against a run-length reference model.
module tb_filter_sched;

    typedef struct packed {
        logic [3:0] qf;
        logic       chg;
        logic [1:0] chg_ch;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] q;
    int         tests = 0;
    int         fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: size 3/div 1, instance 1: size 3/div 0, instance 2: size 5/div 2.
    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int sz = (g == 2) ? 5 : 3;
        localparam int dv = (g == 0) ? 1 : ((g == 1) ? 0 : 2);

        logic [3:0] qf;
`ifdef FILTER_SCHED_CHG_EN
        logic       chg;
        logic [1:0] chg_ch;
`endif

        filter_sched #(.size(sz), .div(dv)) dut (
            .clk   (clk),
            .rst   (rst_n),
            .q     (q),
`ifdef FILTER_SCHED_CHG_EN
            .chg   (chg),
            .chg_ch(chg_ch),
`endif
            .qf    (qf)
        );

        exp_t       exp_q[$];
        exp_t       e_mon;
        logic [3:0] m_qf;
        logic       m_chg;
        logic [1:0] m_ch;
        logic       prev_qf;
        int         run_len [4];
        logic       run_val [4];
        int         n_edge;
        int         slot_ch;

        // Model: edge n after release is a slot if n is a multiple of div+1; a channel
        // filters to v once it has seen size consecutive samples equal to v.
        always @(posedge clk) begin
            if (!rst_n) begin
                m_qf   = 4'd0;
                m_chg  = 1'b0;
                m_ch   = 2'd0;
                n_edge = 0;
                for (int c = 0; c < 4; c++) begin
                    run_len[c] = sz;
                    run_val[c] = 1'b0;
                end
            end else begin
                m_chg = 1'b0;
                if ((n_edge % (dv + 1)) == 0) begin
                    slot_ch = (n_edge / (dv + 1)) % 4;
                    prev_qf = m_qf[slot_ch];
                    if (run_len[slot_ch] >= sz) m_qf[slot_ch] = run_val[slot_ch];
                    if (m_qf[slot_ch] != prev_qf) begin
                        m_chg = 1'b1;
                        m_ch  = 2'(slot_ch);
                    end
                    if (q[slot_ch] == run_val[slot_ch]) begin
                        if (run_len[slot_ch] < sz) run_len[slot_ch]++;
                    end else begin
                        run_val[slot_ch] = q[slot_ch];
                        run_len[slot_ch] = 1;
                    end
                end
                n_edge++;
            end
            exp_q.push_back({m_qf, m_chg, m_ch});
        end

        always @(negedge clk) begin
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                tests++;
                if (qf !== e_mon.qf) begin
                    fails++;
                    $display("[TB] FAIL inst%0d qf @%0t: got %b, want %b", g, $time, qf, e_mon.qf);
                end
`ifdef FILTER_SCHED_CHG_EN
                tests++;
                if ({chg, chg_ch} !== {e_mon.chg, e_mon.chg_ch}) begin
                    fails++;
                    $display("[TB] FAIL inst%0d chg/chg_ch @%0t: got %b/%0d, want %b/%0d",
                             g, $time, chg, chg_ch, e_mon.chg, e_mon.chg_ch);
                end
`endif
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string name);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: check_output(name, {4'h0, inst[0].qf}, 8'h00);
                1: check_output(name, {4'h0, inst[1].qf}, 8'h00);
                default: check_output(name, {4'h0, inst[2].qf}, 8'h00);
            endcase
        end
`ifdef FILTER_SCHED_CHG_EN
        check_output({name, "_chg"}, {5'd0, inst[0].chg, inst[0].chg_ch}, 8'h00);
        check_output({name, "_chg"}, {5'd0, inst[1].chg, inst[1].chg_ch}, 8'h00);
`endif
    endtask

    task automatic apply_stimulus();
        logic [3:0] rise_seq [4];
        int         r;
        rise_seq = '{4'h1, 4'h3, 4'h7, 4'hF};

        // Reset held with all lines high: nothing may leak through.
        rst_n = 1'b0;
        q     = 4'hF;
        repeat (4) begin
            @(negedge clk);
            #1 check_reset_state("reset_hold");
        end

        // Channel 2 rise on the div=1 instance: slots at edges 5, 13, 21, 29.
        q = 4'b0100;
        release_reset();
        repeat (28) @(posedge clk);
        #1 check_output("rise_edge28", {4'h0, inst[0].qf}, 8'h00);
        @(posedge clk);
        #1 check_output("rise_edge29", {4'h0, inst[0].qf}, 8'h04);
`ifdef FILTER_SCHED_CHG_EN
        check_output("rise_chg29", {5'd0, inst[0].chg, inst[0].chg_ch}, 8'h06);
`endif
        @(posedge clk);
        #1 check_output("rise_edge30", {4'h0, inst[0].qf}, 8'h04);
`ifdef FILTER_SCHED_CHG_EN
        check_output("rise_chg30", {5'd0, inst[0].chg, inst[0].chg_ch}, 8'h02);
`endif

        // Six-clock glitch on q[1] covering only the edge-11 slot of channel 1.
        assert_reset();
        q = 4'h0;
        @(negedge clk);
        #1 check_reset_state("reset_glitch");
        release_reset();
        repeat (8) @(posedge clk);
        #2 q = 4'b0010;
        repeat (6) @(posedge clk);
        #2 q = 4'b0000;
        repeat (50) @(posedge clk);
        #1 check_output("glitch_qf", {4'h0, inst[0].qf}, 8'h00);

        // All lines high on the div=0 instance: channels settle on edges 13..16.
        assert_reset();
        q = 4'hF;
        release_reset();
        repeat (12) @(posedge clk);
        #1 check_output("all_edge12", {4'h0, inst[1].qf}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 check_output($sformatf("all_edge%0d", 13 + k), {4'h0, inst[1].qf}, {4'h0, rise_seq[k]});
`ifdef FILTER_SCHED_CHG_EN
            check_output($sformatf("all_chg%0d", 13 + k), {5'd0, inst[1].chg, inst[1].chg_ch},
                         {5'd0, 1'b1, 2'(k)});
`endif
        end

        // Let the div=1 instance reach all-high, start a fall on q[3], then reset.
        repeat (24) @(posedge clk);
        #1 check_output("fall_pre", {4'h0, inst[0].qf}, 8'h0F);
        @(negedge clk);
        #2 q = 4'b0111;
        repeat (5) @(posedge clk);
        assert_reset();
        #1 check_reset_state("reset_midrun");
        @(negedge clk);
        release_reset();

        // Random lines with occasional one-cycle resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #2;
            r = int'($urandom_range(0, 99));
            if (r < 8) q[$urandom_range(0, 3)] = ~q[$urandom_range(0, 3)];
            else if (r < 10) q = 4'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        apply_stimulus();
        #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
